// File: rtl/proc_tracker_pkg.sv
// Shared types and sizing for the process-memory tracker.
package proc_tracker_pkg;

    localparam int PID_WIDTH        = 4;
    localparam int PROC_SLOT_AMOUNT = 8;

    // One tracked regular write burst.
    typedef struct packed {
        logic                 valid;
        logic [PID_WIDTH-1:0] awid;
    } proc_slot_t;

endpackage

// File: rtl/proc_match_find.sv
// Combinational lowest-index match finder over the age-ordered slot vector.
// Slot 0 is the oldest, so the lowest matching index is the oldest burst
// with that ID.
module proc_match_find
    import proc_tracker_pkg::*;
#(
    parameter  int N_SLOTS = PROC_SLOT_AMOUNT,
    localparam int IW      = $clog2(N_SLOTS)
) (
    input  proc_slot_t [N_SLOTS-1:0] i_slot,
    input  logic [PID_WIDTH-1:0]     i_id,
    output logic [N_SLOTS-1:0]       o_onehot,
    output logic [IW-1:0]            o_idx,
    output logic                     o_found
);

    logic [N_SLOTS-1:0] w_hit;

    // Per-slot compare; invalid slots never hit.
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_cmp
        assign w_hit[g] = i_slot[g].valid && (i_slot[g].awid == i_id);
    end

    // Isolate the lowest set bit: x & -x.
    assign o_onehot = w_hit & (~w_hit + N_SLOTS'(1));
    assign o_found  = |w_hit;

    // Priority encode, scanning high to low so the lowest hit wins.
    always_comb begin
        o_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (w_hit[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/proc_tracker.sv
// Process memory for the arbitration path: tracks AWIDs of regular write
// bursts in age order, retires the oldest same-ID entry on each B response,
// and hands release credits to special_memory.
module proc_tracker
    import proc_tracker_pkg::*;
#(
    parameter  int SLOT_AMOUNT = PROC_SLOT_AMOUNT,
    localparam int CW          = $clog2(SLOT_AMOUNT) + 1,
    localparam int IW          = $clog2(SLOT_AMOUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_aw_push,
    input  logic [PID_WIDTH-1:0] i_aw_id,
    input  logic                 i_b_fire,
    input  logic [PID_WIDTH-1:0] i_b_id,
    input  logic                 i_release_ready,
    output logic                 o_proc_full,
    output logic                 o_proc_empty,
    output logic                 o_spec_release,
    output logic [CW-1:0]        o_proc_count,
    output logic                 o_err
);

    localparam logic [CW-1:0] FULL_CNT = CW'(SLOT_AMOUNT);

    proc_slot_t [SLOT_AMOUNT-1:0] r_slot;
    logic [CW-1:0]                r_count;
    logic [CW-1:0]                r_credit;
    logic                         r_err;

    proc_slot_t [SLOT_AMOUNT-1:0] w_slot_nxt;
    proc_slot_t [SLOT_AMOUNT-1:0] w_shifted;
    logic [SLOT_AMOUNT-1:0]       w_match_oh;
    logic [IW-1:0]                w_match_idx;
    logic                         w_found;
    logic                         w_full;
    logic                         w_retire;
    logic                         w_push_ok;
    logic                         w_cr_dec;
    logic [CW-1:0]                w_tail;
    logic [CW-1:0]                w_count_nxt;
    logic [CW-1:0]                w_credit_nxt;
    logic                         w_err_nxt;

    // Search only sees pre-edge state, so a same-cycle push can never match.
    proc_match_find #(.N_SLOTS(SLOT_AMOUNT)) u_find (
        .i_slot   (r_slot),
        .i_id     (i_b_id),
        .o_onehot (w_match_oh),
        .o_idx    (w_match_idx),
        .o_found  (w_found)
    );

    assign w_full    = (r_count == FULL_CNT);
    assign w_retire  = i_b_fire & w_found;
    assign w_push_ok = i_aw_push & ~w_full;
    assign w_cr_dec  = i_release_ready & (r_credit != '0);
    assign w_tail    = r_count - CW'(w_retire);
    // Whole vector moved down one slot; top slot fills with an invalid entry.
    assign w_shifted = r_slot >> $bits(proc_slot_t);

    // Slot update: compact over the retired entry, then append behind the tail.
    always_comb begin
        w_slot_nxt = r_slot;
        for (int i = 0; i < SLOT_AMOUNT; i++) begin
            // The matched slot and every younger one take their upper neighbour.
            if (w_retire && (w_match_oh[i] || (IW'(i) > w_match_idx)))
                w_slot_nxt[i] = w_shifted[i];
        end
        // w_tail < SLOT_AMOUNT whenever a push is accepted.
        if (w_push_ok)
            w_slot_nxt[w_tail[IW-1:0]] = {1'b1, i_aw_id};
    end

    // Occupancy, saturating credit and sticky error next-state.
    always_comb begin
        w_count_nxt  = r_count + CW'(w_push_ok) - CW'(w_retire);
        w_credit_nxt = r_credit;
        if (w_retire && !w_cr_dec) begin
            if (r_credit != FULL_CNT) w_credit_nxt = r_credit + CW'(1);
        end else if (!w_retire && w_cr_dec) begin
            w_credit_nxt = r_credit - CW'(1);
        end
        w_err_nxt = r_err
                  | (i_aw_push & w_full)
                  | (i_b_fire & ~w_found)
                  | (i_release_ready & (r_credit == '0));
    end

    // State registers; reset drops every tracked burst and all credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot   <= '0;
            r_count  <= '0;
            r_credit <= '0;
            r_err    <= 1'b0;
        end else begin
            r_slot   <= w_slot_nxt;
            r_count  <= w_count_nxt;
            r_credit <= w_credit_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign o_proc_full    = w_full;
    assign o_proc_empty   = (r_count == '0);
    assign o_spec_release = (r_credit != '0);
    assign o_proc_count   = r_count;
    assign o_err          = r_err;

endmodule

// File: tb/tb_proc_tracker.sv
// Directed + randomized bench for proc_tracker against a queue-based model.
module tb_proc_tracker;
    import proc_tracker_pkg::*;

    localparam int N  = PROC_SLOT_AMOUNT;
    localparam int CW = $clog2(N) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 aw_push = 1'b0;
    logic [PID_WIDTH-1:0] aw_id = '0;
    logic                 b_fire = 1'b0;
    logic [PID_WIDTH-1:0] b_id = '0;
    logic                 rel = 1'b0;
    logic                 proc_full, proc_empty, spec_release, err;
    logic [CW-1:0]        proc_count;

    proc_tracker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_aw_push       (aw_push),
        .i_aw_id         (aw_id),
        .i_b_fire        (b_fire),
        .i_b_id          (b_id),
        .i_release_ready (rel),
        .o_proc_full     (proc_full),
        .o_proc_empty    (proc_empty),
        .o_spec_release  (spec_release),
        .o_proc_count    (proc_count),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: outstanding IDs oldest-first, credit count, sticky error.
    int q[$];
    int m_credit = 0;
    bit m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/count"}, 32'(proc_count), q.size());
        chk({tag, "/empty"}, 32'(proc_empty), (q.size() == 0) ? 1 : 0);
        chk({tag, "/full"},  32'(proc_full),  (q.size() == N) ? 1 : 0);
        chk({tag, "/rel"},   32'(spec_release), (m_credit > 0) ? 1 : 0);
        chk({tag, "/err"},   32'(err), 32'(m_err));
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        int  pre_credit = m_credit;
        bit  was_full   = (q.size() == N);
        int  inc        = 0;
        int  k          = -1;
        if (b_fire) begin
            foreach (q[j]) if (k < 0 && q[j] == int'(b_id)) k = j;
            if (k >= 0) begin q.delete(k); inc = 1; end
            else m_err = 1'b1;
        end
        if (aw_push) begin
            if (was_full) m_err = 1'b1;
            else q.push_back(int'(aw_id));
        end
        if (rel) begin
            if (pre_credit == 0) m_err = 1'b1;
            else m_credit--;
        end
        m_credit += inc;
        if (m_credit > N) m_credit = N;
    endtask

    task automatic step(input bit p, input int pid, input bit bf, input int bid,
                        input bit r, input string tag);
        aw_push = p; aw_id = PID_WIDTH'(pid);
        b_fire = bf; b_id = PID_WIDTH'(bid);
        rel = r;
        @(posedge clk);
        model_edge();
        #1;
        aw_push = 1'b0; b_fire = 1'b0; rel = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        aw_push = 1'b0; b_fire = 1'b0; rel = 1'b0;
        #2;
        q.delete(); m_credit = 0; m_err = 1'b0;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and basic pushes.
        do_reset();
        chk("rst_empty_const", 32'(proc_empty), 1);
        step(1, 1, 0, 0, 0, "push1");
        step(1, 2, 0, 0, 0, "push2");
        step(1, 3, 0, 0, 0, "push3");
        chk("three_count_const", 32'(proc_count), 3);
        chk("three_rel_const", 32'(spec_release), 0);
        for (int i = 1; i <= 3; i++) step(0, 0, 1, i, 0, "drain");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, "drain_rel");

        // Same-ID ordering.
        step(1, 5, 0, 0, 0, "ord_p5");
        step(1, 2, 0, 0, 0, "ord_p2");
        step(1, 5, 0, 0, 0, "ord_p5b");
        step(0, 0, 1, 5, 0, "ord_b5");
        chk("ord_rel_const", 32'(spec_release), 1);
        step(0, 0, 0, 0, 1, "ord_consume");
        chk("ord_rel_off_const", 32'(spec_release), 0);
        step(0, 0, 1, 5, 0, "ord_b5b");
        step(0, 0, 1, 2, 0, "ord_b2");

        // Fill with two credits already pending, so retires saturate credit.
        for (int i = 0; i < N; i++) step(1, i, 0, 0, 0, "fill");
        chk("fill_full_const", 32'(proc_full), 1);
        step(1, 9, 0, 0, 0, "overflow");
        chk("overflow_err_const", 32'(err), 1);
        for (int i = 0; i < N; i++) step(0, 0, 1, i, 0, "unfill");
        for (int i = 0; i < N; i++) step(0, 0, 0, 0, 1, "sat_rel");
        chk("sat_rel_off_const", 32'(spec_release), 0);

        // Same-cycle push and retire.
        do_reset();
        step(1, 1, 0, 0, 0, "sc_p1");
        step(1, 2, 0, 0, 0, "sc_p2");
        step(1, 7, 1, 1, 0, "sc_both");
        step(0, 0, 1, 7, 0, "sc_b7");
        step(0, 0, 1, 2, 0, "sc_b2");
        step(0, 0, 0, 0, 1, "sc_rel");
        // Retire of an ID pushed in the same cycle must not match it.
        step(1, 4, 1, 4, 0, "sc_self");
        // Push with retire while full is still a dropped push.
        do_reset();
        for (int i = 0; i < N; i++) step(1, i, 0, 0, 0, "sf_fill");
        step(1, 11, 1, 0, 0, "sf_both");

        // Protocol errors.
        do_reset();
        step(1, 3, 0, 0, 0, "pe_p3");
        step(0, 0, 1, 9, 0, "pe_nomatch");
        do_reset();
        step(0, 0, 0, 0, 1, "pe_nocredit");

        // Asynchronous reset mid-operation with 4 entries and 2 credits.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, i + 1, 0, 0, 0, "ar_fill");
        step(0, 0, 1, 1, 0, "ar_b1");
        step(0, 0, 1, 2, 0, "ar_b2");
        #3;
        rst_n = 1'b0;
        #1;
        q.delete(); m_credit = 0; m_err = 1'b0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 3, 0, "ar_late_b");

        // Randomized traffic with periodic reset.
        for (int c = 0; c < 600; c++) begin
            bit p, bf, r;
            int pid, bid;
            if (c % 75 == 0) do_reset();
            p   = ($urandom_range(0, 99) < 50);
            pid = $urandom_range(0, 7);
            bf  = ($urandom_range(0, 99) < 40);
            if (q.size() > 0 && $urandom_range(0, 99) < 90)
                bid = q[$urandom_range(0, q.size() - 1)];
            else
                bid = $urandom_range(0, 15);
            r   = (m_credit > 0) ? ($urandom_range(0, 99) < 45)
                                 : ($urandom_range(0, 99) < 3);
            step(p, pid, bf, bid, r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
